pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (EX/MEM and similar). It adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall-cycle counter.
- Sits between any two pipeline stages. The upstream stage pushes one instruction beat (ctrl + data); the downstream stage may stall it.
- The control field is kept separate from data, so flushed or empty slots always present zero control (no spurious RegWrite/MemWrite).

Parameters:
- CTRL_W, 3, width of control bundle (e.g. RegWrite, M2Reg, MemWrite).
- DATA_W, 69, width of data bundle (e.g. result 32 + b 32 + TargetReg 5).
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept a beat; registered, equals NOT skid_full.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bundle of the main entry.
- out_data  out  DATA_W  data bundle of the main entry.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- One clock, clk. Reset clrn is asynchronous, active-low.
- Reset (clrn=0), effective immediately without a clock edge:
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - out_ctrl=0, out_data=0, skid regs=0, stall_cnt=0.
  - Reset mid-operation discards all held beats.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- State is {main_valid, skid_valid}: EMPTY=00, ONE=10, FULL=11. State 01 is illegal and never reached.
- EMPTY:
  - accept loads the beat into main and goes to ONE.
  - No accept stays in EMPTY.
- ONE:
  - accept & drain loads main with the new beat; stays ONE.
  - accept & !drain places the new beat in skid; goes to FULL; in_ready=0 from the next cycle.
  - !accept & drain goes to EMPTY.
  - Neither: hold.
- FULL:
  - in_ready=0, so accept is impossible.
  - drain moves skid into main, clears skid and goes to ONE.
  - No drain: hold.
- Latency: one cycle from accept to out_valid when empty. Throughput is one beat per cycle with out_ready held high. No combinational path from out_ready to in_ready.
- Order: beats leave strictly in acceptance order. Skid is never bypassed.
- Data held stable: out_ctrl and out_data do not change while out_valid=1 and out_ready=0.
- flush=1 at a rising edge:
  - Goes to EMPTY.
  - out_ctrl and skid ctrl are cleared to 0. Data regs may keep their values.
  - A beat offered in the same cycle is discarded even if in_ready=1.
  - A drain in the same cycle still counts as delivered downstream; the downstream stage owns that decision.
  - flush has priority over every other transition.
- Empty slots: out_ctrl=0 whenever out_valid=0, in every state.
- stall_cnt:
  - Increments by 1 on each clock with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Not cleared by flush; cleared only by reset.
- Widths: all ports are sized by parameters exactly as listed. No sign extension or packing is done inside the block.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams ST_EMPTY, ST_ONE, ST_FULL.
  - Default CTRL_W/DATA_W constants for the EX/MEM bundle.
  - Bit-index constants for the control bundle (CTRL_REGWRITE=0, CTRL_M2REG=1, CTRL_MEMWRITE=2).
- One natural sub-module: pipe_sat_counter (CNT_W-bit saturating counter with enable and async active-low clear), used for stall_cnt.

Test Plan:
- Reset release, in_valid=0 -> out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0. Assert clrn=0 mid-stream while in FULL -> all outputs return to reset values without a clock edge.
- Streaming: out_ready=1, beats data=1..8, ctrl=3'b101, one per cycle -> out_data 1..8 on consecutive cycles, first one cycle after first accept; in_ready constantly 1.
- Backpressure:
  - Stimulus: beats A=0x11, B=0x22, C=0x33 pushed back-to-back; out_ready=0 for 4 cycles, then 1.
  - in_ready: drops after B is accepted; C waits upstream.
  - Output: out_data holds 0x11 throughout.
  - stall_cnt: reaches 4.
  - On release: output order is 0x11, 0x22, 0x33.
- Flush in FULL with ctrl=3'b111, plus a simultaneous in_valid beat 0x44 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x44 never appears at the output.
- Simultaneous accept & drain in ONE: main=0x55 draining, new 0x66 offered -> next cycle out_data=0x66, skid stays empty, in_ready=1.
- Saturation: CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: state encoding, default
// EX/MEM bundle widths and control-bit positions.
package pipe_pkg;

  localparam int CTRL_W_EXMEM = 3;
  localparam int DATA_W_EXMEM = 69;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_M2REG    = 1;
  localparam int CTRL_MEMWRITE = 2;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Up-counter with enable that sticks at all-ones; asynchronous active-low clear.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clrn,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_EXMEM,
  parameter int DATA_W = DATA_W_EXMEM,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves on a rising edge only when its valid and ready are
  // both high; valid must not depend on ready, and in_ready/out_valid come
  // straight from state flops so no combinational path crosses the block.

  pipe_state_e       r_state, w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0] r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;

  logic w_accept;
  logic w_drain;

  assign out_valid = r_state[1];
  assign in_ready  = ~r_state[0];
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  // Control is zeroed whenever a slot empties, so an empty main slot never
  // presents a live RegWrite/MemWrite.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
            w_state_nxt     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_accept) begin
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
            w_state_nxt     = ST_FULL;
          end else if (w_drain) begin
            w_main_ctrl_nxt = '0;
            w_state_nxt     = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
            w_state_nxt     = ST_ONE;
          end
        end
        default: begin
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
          w_state_nxt     = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clrn  (clrn),
    .i_en    (out_valid & ~out_ready),
    .o_count (stall_cnt)
  );

endmodule
